// File: rtl/key_debounce_pkg.sv
// Shared definitions for key conditioning blocks: FSM state encoding and the
// stable-time cycle count derivation, reused by multi-key wrappers.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    DOWN         = 2'd2,
    RELEASE_WAIT = 2'd3
  } kd_state_e;

  // Number of clk cycles the synchronised key must stay stable.
  function automatic int db_cycles(input int clk_freq_hz, input int debounce_ms);
    return clk_freq_hz / 1000 * debounce_ms;
  endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Key pin and conditioned key events, plus the filter FSM state for observation.
// key_flag/key_release are single-cycle registered strobes (no back-pressure);
// key_state is the debounced level, 1 = pressed.
interface key_debounce_if;
  logic                          key_in;
  logic                          key_flag;
  logic                          key_release;
  logic                          key_state;
  key_debounce_pkg::kd_state_e   state_dbg;

  modport master (
    output key_in,
    input  key_flag, key_release, key_state, state_dbg
  );

  modport slave (
    input  key_in,
    output key_flag, key_release, key_state, state_dbg
  );
endinterface

// File: rtl/key_debounce_sync_2ff.sv
// 1-bit two-flop synchroniser with asynchronous active-high reset to a
// parameterised level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic ff1;
  logic ff2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff1 <= RST_VAL;
      ff2 <= RST_VAL;
    end else begin
      ff1 <= d;
      ff2 <= ff1;
    end
  end

  assign q = ff2;

endmodule

// File: rtl/key_debounce.sv
// Push-button conditioner: synchronises a raw key, filters it with a
// stable-time counter and emits press/release strobes and a debounced level.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 50_000_000,
  parameter int DEBOUNCE_MS    = 20,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic     clk,
  input  logic     rst,
  key_debounce_if.slave kif
);

  localparam int   DB_CYCLES = db_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);
  localparam int   CW        = $clog2(DB_CYCLES);
  localparam logic REL_LEVEL = (KEY_ACTIVE_LOW != 0);

  generate
    if (DB_CYCLES < 2) begin : g_bad_params
      $error("key_debounce: DB_CYCLES must be at least 2");
    end
  endgenerate

  logic      key_raw_sync;
  logic      key_sync;
  kd_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic      flag_q, flag_d;
  logic      rel_q, rel_d;
  logic      level_q, level_d;
  logic      cnt_last;

  // Reset loads the released pin level so a held key still shows a fresh press.
  sync_2ff #(.RST_VAL(REL_LEVEL)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (kif.key_in),
    .q   (key_raw_sync)
  );

  assign key_sync = (KEY_ACTIVE_LOW != 0) ? ~key_raw_sync : key_raw_sync;
  assign cnt_last = (cnt_q == CW'(DB_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      rel_q   <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      rel_q   <= rel_d;
      level_q <= level_d;
    end
  end

  // Counter is cleared on every state entry, so it never passes DB_CYCLES-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (key_sync) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!key_sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_last) begin
          state_d = DOWN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DOWN: begin
        if (!key_sync) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (key_sync) begin
          state_d = DOWN;
          cnt_d   = '0;
        end else if (cnt_last) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  always_comb begin
    flag_d  = 1'b0;
    rel_d   = 1'b0;
    level_d = level_q;
    if (state_q == PRESS_WAIT && key_sync && cnt_last) begin
      flag_d  = 1'b1;
      level_d = 1'b1;
    end
    if (state_q == RELEASE_WAIT && !key_sync && cnt_last) begin
      rel_d   = 1'b1;
      level_d = 1'b0;
    end
  end

  assign kif.key_flag    = flag_q;
  assign kif.key_release = rel_q;
  assign kif.key_state   = level_q;
  assign kif.state_dbg   = state_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DB_CYCLES = 5 (1 kHz clock, 5 ms).
module tb_key_debounce;
  import key_debounce_pkg::*;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   flag_cnt = 0;
  int   rel_cnt = 0;
  int   last_evt = 2;
  int   f0;
  int   r0;

  key_debounce_if kif();

  key_debounce #(
    .CLK_FREQ_HZ    (1000),
    .DEBOUNCE_MS    (5),
    .KEY_ACTIVE_LOW (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kif (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Leaves the caller 1 time unit after the n-th rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse bookkeeping: strobes never coincide and strictly alternate.
  always @(negedge clk) begin
    if (!rst) begin
      if (kif.key_flag || kif.key_release)
        check("no_coincide", {31'd0, kif.key_flag & kif.key_release}, 32'd0);
      if (kif.key_flag) begin
        flag_cnt++;
        check("alt_flag_prev", last_evt, 2);
        last_evt = 1;
      end
      if (kif.key_release) begin
        rel_cnt++;
        check("alt_rel_prev", last_evt, 1);
        last_evt = 2;
      end
    end
  end

  initial begin
    rst    = 1'b1;
    kif.key_in = 1'b1;
    tick(3);
    check("rst_flag", kif.key_flag, 0);
    check("rst_rel", kif.key_release, 0);
    check("rst_state", kif.key_state, 0);
    check("rst_fsm", kif.state_dbg, IDLE);
    rst = 1'b0;
    tick(3);
    check("idle_fsm", kif.state_dbg, IDLE);

    // Clean press held 30 cycles: single strobe at edge 7, no auto-repeat.
    f0 = flag_cnt;
    kif.key_in = 1'b0;
    for (int e = 0; e <= 10; e++) begin
      tick(1);
      check("clean_flag", kif.key_flag, (e == 7));
      check("clean_state", kif.key_state, (e >= 7));
      check("clean_rel", kif.key_release, 0);
    end
    tick(19);
    check("clean_fsm", kif.state_dbg, DOWN);
    check("clean_once", flag_cnt - f0, 1);

    // Clean release.
    kif.key_in = 1'b1;
    for (int e = 0; e <= 10; e++) begin
      tick(1);
      check("rel_pulse", kif.key_release, (e == 7));
      check("rel_state", kif.key_state, (e < 7));
      check("rel_flag", kif.key_flag, 0);
    end
    tick(5);
    check("rel_fsm", kif.state_dbg, IDLE);

    // Bouncy press: 0,1,0,1 for two cycles each, then settle at 0.
    for (int p = 0; p < 4; p++) begin
      kif.key_in = (p % 2 == 1);
      for (int c = 0; c < 2; c++) begin
        tick(1);
        check("bounce_flag", kif.key_flag, 0);
        check("bounce_state", kif.key_state, 0);
      end
    end
    kif.key_in = 1'b0;
    for (int e = 0; e <= 10; e++) begin
      tick(1);
      check("bouncy_flag", kif.key_flag, (e == 7));
      check("bouncy_state", kif.key_state, (e >= 7));
    end
    tick(10);

    // Release glitch of 3 cycles while pressed is rejected.
    r0 = rel_cnt;
    kif.key_in = 1'b1;
    tick(3);
    kif.key_in = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick(1);
      check("glitch_rel", kif.key_release, 0);
      check("glitch_state", kif.key_state, 1);
    end
    check("glitch_fsm", kif.state_dbg, DOWN);
    kif.key_in = 1'b1;
    tick(12);
    check("glitch_after_state", kif.key_state, 0);
    check("glitch_after_rels", rel_cnt - r0, 1);

    // Reset in the middle of the press filter.
    kif.key_in = 1'b0;
    tick(5);
    check("mid_fsm", kif.state_dbg, PRESS_WAIT);
    rst = 1'b1;
    #1;
    check("mid_rst_fsm", kif.state_dbg, IDLE);
    check("mid_rst_flag", kif.key_flag, 0);
    check("mid_rst_state", kif.key_state, 0);
    tick(2);
    check("mid_rst_hold_flag", kif.key_flag, 0);
    check("mid_rst_hold_rel", kif.key_release, 0);
    rst = 1'b0;
    for (int e = 0; e <= 10; e++) begin
      tick(1);
      check("post_rst_flag", kif.key_flag, (e == 7));
      check("post_rst_state", kif.key_state, (e >= 7));
    end
    kif.key_in = 1'b1;
    tick(12);
    check("post_rst_release", kif.key_state, 0);

    // Ten press/release cycles.
    f0 = flag_cnt;
    r0 = rel_cnt;
    for (int k = 0; k < 10; k++) begin
      kif.key_in = 1'b0;
      tick(20);
      kif.key_in = 1'b1;
      tick(20);
    end
    check("ten_flags", flag_cnt - f0, 10);
    check("ten_rels", rel_cnt - r0, 10);
    check("total_flags", flag_cnt, 13);
    check("total_rels", rel_cnt, 13);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
